// File: rtl/mac_gate_ctrl.sv
// Per-column clock-gate controller: idle columns are gated off, wake-ups are
// admitted one per cycle by a round-robin arbiter, ready follows a settle delay.
module mac_gate_ctrl #(
    parameter int COL      = 8,
    parameter int IDLE_CYC = 4,
    parameter int WAKE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [COL-1:0]             col_req,
    input  logic                       force_on,
    output logic [COL-1:0]             gate_en,
    output logic [COL-1:0]             col_ready,
    output logic [$clog2(COL+1)-1:0]   active_cnt
);

    localparam int PW = (COL > 1) ? $clog2(COL) : 1;
    localparam int WW = $clog2(WAKE_CYC + 1);
    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam int CW = $clog2(COL + 1);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;

    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYC - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);

    logic [COL-1:0] req_eff;
    logic [COL-1:0] cand;
    logic [COL-1:0] grant;
    logic           grant_vld;
    logic [PW-1:0]  grant_idx;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [COL-1:0] gate_en_d, col_ready_d;
    logic [COL-1:0] gate_en_q, col_ready_q;
    logic [CW-1:0]  active_cnt_d, active_cnt_q;

    assign req_eff = col_req | {COL{force_on}};

    // Scan candidates starting at rr_ptr, wrapping; the first hit wins.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_w;
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_w     = '0;
        for (int k = 0; k < COL; k++) begin
            idx   = (int'(rr_ptr_q) + k) % COL;
            idx_w = PW'(idx);
            if (!grant_vld && cand[idx_w]) begin
                grant_vld        = 1'b1;
                grant[idx_w]     = 1'b1;
                grant_idx        = idx_w;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (int'(grant_idx) == COL - 1) ? '0 : grant_idx + PW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COL; gi++) begin : g_col
            logic [1:0]    state_q, state_d;
            logic [WW-1:0] wake_q, wake_d;
            logic [IW-1:0] idle_q, idle_d;

            assign cand[gi] = (state_q == ST_OFF) && req_eff[gi];

            always_comb begin
                state_d = state_q;
                wake_d  = wake_q;
                idle_d  = idle_q;
                case (state_q)
                    ST_OFF: begin
                        if (grant[gi]) begin
                            state_d = ST_WAKE;
                            wake_d  = '0;
                        end
                    end
                    ST_WAKE: begin
                        // Requests are ignored here so a started wake always completes.
                        if (wake_q == WAKE_LAST) begin
                            state_d = ST_ON;
                            idle_d  = '0;
                        end else begin
                            wake_d = wake_q + WW'(1);
                        end
                    end
                    ST_ON: begin
                        if (req_eff[gi]) begin
                            idle_d = '0;
                        end else if (idle_q == IDLE_LAST) begin
                            state_d = ST_OFF;
                            idle_d  = '0;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end
                    default: state_d = ST_OFF;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= ST_OFF;
                    wake_q  <= '0;
                    idle_q  <= '0;
                end else begin
                    state_q <= state_d;
                    wake_q  <= wake_d;
                    idle_q  <= idle_d;
                end
            end

            assign gate_en_d[gi]   = (state_d != ST_OFF);
            assign col_ready_d[gi] = (state_d == ST_ON);
        end
    endgenerate

    always_comb begin
        active_cnt_d = '0;
        for (int i = 0; i < COL; i++) begin
            active_cnt_d = active_cnt_d + CW'(gate_en_d[i]);
        end
    end

    // Outputs come straight from flops so the clk_gate enable never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            gate_en_q    <= '0;
            col_ready_q  <= '0;
            active_cnt_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            gate_en_q    <= gate_en_d;
            col_ready_q  <= col_ready_d;
            active_cnt_q <= active_cnt_d;
        end
    end

    assign gate_en    = gate_en_q;
    assign col_ready  = col_ready_q;
    assign active_cnt = active_cnt_q;

endmodule

// File: tb/tb_mac_gate_ctrl.sv
// Scoreboard bench for mac_gate_ctrl: a timestamp-based reference model pushes
// expected outputs; a monitor pops and compares one entry per clock.
module tb_mac_gate_ctrl;

    localparam int COL = 4;
    localparam int IDLE_CYC = 4;
    localparam int WAKE_CYC = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [COL-1:0] col_req;
    logic           force_on;
    logic [COL-1:0] gate_en;
    logic [COL-1:0] col_ready;
    logic [2:0]     active_cnt;

    mac_gate_ctrl #(.COL(COL), .IDLE_CYC(IDLE_CYC), .WAKE_CYC(WAKE_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .col_req    (col_req),
        .force_on   (force_on),
        .gate_en    (gate_en),
        .col_ready  (col_ready),
        .active_cnt (active_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [COL-1:0] ge;
        logic [COL-1:0] rdy;
        logic [2:0]     cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a column is powered from its grant cycle g+1, is ready
    // from g+1+WAKE_CYC, and drops after IDLE_CYC consecutive request-free
    // ready cycles counted from idle_from.
    bit powered[COL];
    int grant_cyc[COL];
    int idle_from[COL];
    int rr;
    int cyc = 0;

    task automatic model_step(input logic rst, input logic [COL-1:0] req, input logic fon);
        logic [COL-1:0] r;
        logic [COL-1:0] cnd;
        exp_t e;
        int n;
        r = req | {COL{fon}};
        if (rst) begin
            for (int i = 0; i < COL; i++) powered[i] = 0;
            rr = 0;
        end else begin
            for (int i = 0; i < COL; i++) cnd[i] = !powered[i] && r[i];
            for (int i = 0; i < COL; i++) begin
                if (powered[i] && cyc >= grant_cyc[i] + 1 + WAKE_CYC) begin
                    if (r[i]) idle_from[i] = cyc + 1;
                    else if (cyc - idle_from[i] + 1 >= IDLE_CYC) powered[i] = 0;
                end
            end
            for (int k = 0; k < COL; k++) begin
                int j;
                j = (rr + k) % COL;
                if (cnd[j]) begin
                    powered[j]   = 1;
                    grant_cyc[j] = cyc;
                    idle_from[j] = cyc + 1 + WAKE_CYC;
                    rr = (j + 1) % COL;
                    break;
                end
            end
        end
        n = 0;
        for (int i = 0; i < COL; i++) begin
            e.ge[i]  = powered[i];
            e.rdy[i] = powered[i] && (cyc + 1 >= grant_cyc[i] + 1 + WAKE_CYC);
            n += int'(powered[i]);
        end
        e.cnt = 3'(n);
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic drive(input logic rst, input logic [COL-1:0] req, input logic fon);
        @(negedge clk);
        reset    = rst;
        col_req  = req;
        force_on = fon;
        model_step(rst, req, fon);
    endtask

    task automatic run(input int n, input logic rst, input logic [COL-1:0] req, input logic fon);
        for (int i = 0; i < n; i++) drive(rst, req, fon);
    endtask

    // Monitor: outputs are valid every cycle, so one entry is consumed per edge.
    initial begin
        exp_t e;
        int t;
        t = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 3;
                if (gate_en !== e.ge) begin
                    errors++;
                    $display("FAIL gate_en txn=%0d got=%b exp=%b", t, gate_en, e.ge);
                end
                if (col_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL col_ready txn=%0d got=%b exp=%b", t, col_ready, e.rdy);
                end
                if (active_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL active_cnt txn=%0d got=%0d exp=%0d", t, active_cnt, e.cnt);
                end
                $display("txn %0d gate_en=%b col_ready=%b active_cnt=%0d", t, gate_en, col_ready, active_cnt);
                t++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; col_req = '0; force_on = 1'b0;
        // Reset with all requests high, then column 0 first after release.
        run(2, 1'b1, 4'hF, 1'b0);
        run(6, 1'b0, 4'hF, 1'b0);
        run(6, 1'b0, 4'h0, 1'b0);
        // Single wake of column 2.
        run(5, 1'b0, 4'b0100, 1'b0);
        run(6, 1'b0, 4'h0, 1'b0);
        // Column 1 alone moves rr_ptr to 2, then full contention.
        run(1, 1'b0, 4'b0010, 1'b0);
        run(8, 1'b0, 4'h0, 1'b0);
        run(7, 1'b0, 4'hF, 1'b0);
        // Idle reprieve on column 1.
        run(3, 1'b0, 4'b0000, 1'b0);
        run(1, 1'b0, 4'b0010, 1'b0);
        run(6, 1'b0, 4'b0000, 1'b0);
        // One-cycle request on column 0, then a wake cut short by reset.
        run(1, 1'b0, 4'b0001, 1'b0);
        run(9, 1'b0, 4'b0000, 1'b0);
        run(1, 1'b0, 4'b0001, 1'b0);
        run(1, 1'b0, 4'b0000, 1'b0);
        run(1, 1'b1, 4'b0000, 1'b0);
        run(3, 1'b0, 4'b0000, 1'b0);
        // force_on wakes everything and holds it, release gates all off together.
        run(12, 1'b0, 4'b0000, 1'b1);
        run(7, 1'b0, 4'b0000, 1'b0);
        // Randomized traffic with occasional force_on and reset.
        for (int i = 0; i < 400; i++) begin
            logic [COL-1:0] rq;
            logic fo, rs;
            rq = 4'($urandom) & 4'($urandom);
            fo = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 79) == 0);
            drive(rs, rq, fo);
        end
        run(3, 1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_gate_ctrl.md
# mac_gate_ctrl

Per-column clock-gate controller for the MAC array. It drives the `en` input of one `clk_gate` cell per MAC column. Columns are powered down after a run of idle cycles. Wake-ups are admitted by a round-robin arbiter at no more than one column per cycle, which limits inrush current. A column is flagged ready only after its gated clock has run long enough to be stable.

## Interface
- `COL`, 8: number of MAC columns / clock-gate cells.
- `IDLE_CYC`, 4: consecutive idle cycles in ON before the column is gated off (≥1).
- `WAKE_CYC`, 2: cycles spent in WAKE with the clock running before the column is ready (≥1).
- `clk`  in  1: array clock, ungated. Single clock domain; all state updates on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `col_req`  in  COL: bit i high means column i has work this cycle (level, not pulse).
- `force_on`  in  1: treat every column as requesting; ON columns never gate off.
- `gate_en`  out  COL: registered enable to `clk_gate` i; high in WAKE and ON.
- `col_ready`  out  COL: registered; high only in ON; data is issued to column i only when `col_req[i] & col_ready[i]`.
- `active_cnt`  out  $clog2(COL+1): registered count of set `gate_en` bits.

## Operation
- Per-column FSM with three states: OFF, WAKE, ON. Each column keeps a wake counter of width $clog2(WAKE_CYC+1) and an idle counter of width $clog2(IDLE_CYC+1).
- Effective request: `r[i] = col_req[i] | force_on`.
- **OFF**
  - The column is a wake candidate when `r[i]` is high.
  - If granted, it moves to WAKE and clears its wake counter.
  - If not granted, it stays OFF and keeps requesting.
- **Wake arbiter**
  - Combinational, over the candidate set.
  - Grants the first candidate at index ≥ `rr_ptr`, wrapping modulo COL.
  - At most one grant per cycle.
  - On a grant, `rr_ptr` becomes (granted index + 1) mod COL. With no grant, `rr_ptr` holds.
- **WAKE**
  - The wake counter increments each cycle.
  - When it equals WAKE_CYC-1, the column moves to ON and clears its idle counter.
  - `r[i]` is ignored in WAKE. A request that drops mid-wake still completes to ON.
- **ON**
  - If `r[i]` is high, the idle counter clears.
  - Otherwise the idle counter increments.
  - When the idle counter equals IDLE_CYC-1 with `r[i]` low, the column moves to OFF.
- **Outputs:** `gate_en[i]`, `col_ready[i]` and `active_cnt` are registered from the next-state values, so they change only at posedge. This keeps the `clk_gate` latch input glitch-free.

## Timing
- **Reset**
  - Next posedge after `reset` is high: all columns OFF, all counters 0, `rr_ptr`=0, `gate_en`=0, `col_ready`=0, `active_cnt`=0.
  - Mid-operation reset overrides every transition, including an in-flight WAKE.
- **Wake latency**
  - Column OFF, `r[i]` high and granted in cycle t.
  - `gate_en[i]`=1 from cycle t+1.
  - `col_ready[i]`=1 from cycle t+1+WAKE_CYC (t+3 with default parameters).
- **Contention:** with k simultaneous candidates, the last one to be served is granted k-1 cycles later.
- **Gate-off timing**
  - With `col_req[i]` low in cycles t..t+IDLE_CYC-1, `gate_en[i]` and `col_ready[i]` fall at t+IDLE_CYC.
  - A request in the final idle cycle cancels the gate-off and clears the idle counter.
- **Re-request after gate-off:** a request in the cycle after gate-off is a fresh OFF candidate. The minimum OFF time is therefore one cycle.
- **force_on**
  - Asserting it wakes all OFF columns, one per cycle, in round-robin order.
  - Deasserting it starts idle counting for columns whose `col_req` is low.
- **active_cnt:** always equals popcount(`gate_en`). It changes by at most +1 per cycle on wake (one grant); it can drop by several in one cycle on gate-off.

## Test plan
Defaults for all scenarios: COL=4, IDLE_CYC=4, WAKE_CYC=2.
- **Reset:** hold `reset` 2 cycles with `col_req`=4'hF → `gate_en`=0, `col_ready`=0, `active_cnt`=0 at every sampled edge; after release, column 0 is granted first.
- **Single wake:** `col_req`=4'b0100 from cycle t → `gate_en`=4'b0100 at t+1, `col_ready`=4'b0100 at t+3, `active_cnt`=1.
- **Contention:** `col_req`=4'hF at cycle t with `rr_ptr`=2 → `gate_en` bits set in order 2,3,0,1 at t+1..t+4; `active_cnt` steps 1,2,3,4.
- **Idle gate-off with reprieve:**
  - ON column 1 gets `col_req[1]` low for 3 cycles, high for 1, then low for 4 → no gate-off after the first 3 idle cycles.
  - `gate_en[1]` falls exactly 4 cycles after the last request cycle.
- **Request drop during WAKE and mid-wake reset:**
  - Column 0 requests for 1 cycle only → completes WAKE, ready 2 cycles after `gate_en` rises, then gates off after 4 idle cycles.
  - Repeat the wake and assert `reset` during WAKE → `gate_en`=0 on the next edge.
- **force_on:**
  - `force_on`=1 with `col_req`=0 → all 4 columns wake, one per cycle, and stay ON indefinitely.
  - Deassert `force_on` → all four `gate_en` bits fall together 4 cycles later; `active_cnt` goes 4→0.
